// File: rtl/debug_cmd_sync.sv
// System-clock receiver for the CPU debug slave: re-times JTAG update strobes,
// queues completed scans and issues per-instruction action strobes with a held jdo word.
module debug_cmd_sync #(
    parameter int SR_W        = 38,
    parameter int IR_W        = 2,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4,
    localparam int NCH        = 2 ** IR_W,
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              vs_uir,
    input  logic              vs_udr,
    input  logic [IR_W-1:0]   ir_in,
    input  logic [SR_W-1:0]   sr,
    input  logic              action_ready,
    input  logic              ovf_clr,
    output logic              action_valid,
    output logic [IR_W-1:0]   action_ir,
    output logic [SR_W-1:0]   jdo,
    output logic [NCH-1:0]    take_action,
    output logic [NCH-1:0]    take_no_action,
    output logic [CNT_W-1:0]  fifo_count,
    output logic              overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int ENT_W = IR_W + SR_W;

    logic [SYNC_STAGES-1:0] uir_sync_q, uir_sync_d;
    logic [SYNC_STAGES-1:0] udr_sync_q, udr_sync_d;
    logic [SYNC_STAGES-1:0] fill_q, fill_d;
    logic                   uir_dly_q, uir_dly_d;
    logic                   udr_dly_q, udr_dly_d;
    logic                   arm_uir_q, arm_uir_d;
    logic                   arm_udr_q, arm_udr_d;
    logic [IR_W-1:0]        ir_reg_q, ir_reg_d;
    logic [ENT_W-1:0]       mem_q [FIFO_DEPTH];
    logic [ENT_W-1:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [SR_W-1:0]        jdo_q, jdo_d;
    logic [NCH-1:0]         take_action_q, take_action_d;
    logic [NCH-1:0]         take_no_action_q, take_no_action_d;
    logic                   overflow_q, overflow_d;

    logic                   uir_evt, udr_evt;
    logic                   pop, push, full, drop;
    logic [ENT_W-1:0]       head;
    logic [IR_W-1:0]        head_ir;
    logic [SR_W-1:0]        head_sr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        uir_sync_d = {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
        udr_sync_d = {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
        // fill marks when the last sync stage holds a real sample rather than its reset value,
        // so a level held high through reset cannot arm its input
        fill_d     = {fill_q[SYNC_STAGES-2:0], 1'b1};
        uir_dly_d  = uir_sync_q[SYNC_STAGES-1];
        udr_dly_d  = udr_sync_q[SYNC_STAGES-1];
        arm_uir_d  = arm_uir_q | (fill_q[SYNC_STAGES-1] & ~uir_sync_q[SYNC_STAGES-1]);
        arm_udr_d  = arm_udr_q | (fill_q[SYNC_STAGES-1] & ~udr_sync_q[SYNC_STAGES-1]);

        uir_evt = arm_uir_q & uir_sync_q[SYNC_STAGES-1] & ~uir_dly_q;
        udr_evt = arm_udr_q & udr_sync_q[SYNC_STAGES-1] & ~udr_dly_q;

        ir_reg_d = uir_evt ? ir_in : ir_reg_q;

        head    = mem_q[rd_ptr_q];
        head_ir = head[ENT_W-1:SR_W];
        head_sr = head[SR_W-1:0];

        pop  = (count_q != '0) & action_ready;
        full = (count_q == CNT_W'(FIFO_DEPTH));
        push = udr_evt & (~full | pop);
        drop = udr_evt & full & ~pop;

        // push takes the pre-update ir_reg so a coincident uir event affects only later scans
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = {ir_reg_q, sr};
        end
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        jdo_d            = pop ? head_sr : jdo_q;
        take_action_d    = '0;
        take_no_action_d = '0;
        if (pop) begin
            if (head_sr[SR_W-1]) begin
                take_action_d[head_ir] = 1'b1;
            end else begin
                take_no_action_d[head_ir] = 1'b1;
            end
        end

        if (drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            uir_sync_q       <= '0;
            udr_sync_q       <= '0;
            fill_q           <= '0;
            uir_dly_q        <= 1'b0;
            udr_dly_q        <= 1'b0;
            arm_uir_q        <= 1'b0;
            arm_udr_q        <= 1'b0;
            ir_reg_q         <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            jdo_q            <= '0;
            take_action_q    <= '0;
            take_no_action_q <= '0;
            overflow_q       <= 1'b0;
        end else begin
            uir_sync_q       <= uir_sync_d;
            udr_sync_q       <= udr_sync_d;
            fill_q           <= fill_d;
            uir_dly_q        <= uir_dly_d;
            udr_dly_q        <= udr_dly_d;
            arm_uir_q        <= arm_uir_d;
            arm_udr_q        <= arm_udr_d;
            ir_reg_q         <= ir_reg_d;
            mem_q            <= mem_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
            jdo_q            <= jdo_d;
            take_action_q    <= take_action_d;
            take_no_action_q <= take_no_action_d;
            overflow_q       <= overflow_d;
        end
    end

    assign action_valid   = (count_q != '0);
    assign action_ir      = head_ir;
    assign jdo            = jdo_q;
    assign take_action    = take_action_q;
    assign take_no_action = take_no_action_q;
    assign fifo_count     = count_q;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_debug_cmd_sync.sv
// Directed bench for debug_cmd_sync at default parameters; expected values are hand-computed.
module tb_debug_cmd_sync;

    logic        clk;
    logic        reset_n;
    logic        vs_uir;
    logic        vs_udr;
    logic [1:0]  ir_in;
    logic [37:0] sr;
    logic        action_ready;
    logic        ovf_clr;
    logic        action_valid;
    logic [1:0]  action_ir;
    logic [37:0] jdo;
    logic [3:0]  take_action;
    logic [3:0]  take_no_action;
    logic [2:0]  fifo_count;
    logic        overflow;

    int n_assert = 0;
    int n_fail   = 0;

    debug_cmd_sync dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .vs_uir         (vs_uir),
        .vs_udr         (vs_udr),
        .ir_in          (ir_in),
        .sr             (sr),
        .action_ready   (action_ready),
        .ovf_clr        (ovf_clr),
        .action_valid   (action_valid),
        .action_ir      (action_ir),
        .jdo            (jdo),
        .take_action    (take_action),
        .take_no_action (take_no_action),
        .fifo_count     (fifo_count),
        .overflow       (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 64'(action_valid), 64'd0);
        chk({tag, "_ir"},    64'(action_ir), 64'd0);
        chk({tag, "_jdo"},   64'(jdo), 64'd0);
        chk({tag, "_ta"},    64'(take_action), 64'd0);
        chk({tag, "_tna"},   64'(take_no_action), 64'd0);
        chk({tag, "_cnt"},   64'(fifo_count), 64'd0);
        chk({tag, "_ovf"},   64'(overflow), 64'd0);
    endtask

    task automatic uir_scan(input logic [1:0] ir);
        ir_in  = ir;
        vs_uir = 1'b1;
        repeat (4) tick();
        vs_uir = 1'b0;
        repeat (4) tick();
    endtask

    // push lands on the third edge after vs_udr rises; returns after the line has settled low
    task automatic udr_scan(input logic [37:0] data);
        sr     = data;
        vs_udr = 1'b1;
        repeat (3) tick();
        vs_udr = 1'b0;
        repeat (3) tick();
    endtask

    logic [37:0] dq [5];
    logic [3:0]  exp_ta, exp_tna;

    initial begin
        reset_n = 1'b0; vs_uir = 1'b0; vs_udr = 1'b0; ir_in = '0; sr = '0;
        action_ready = 1'b0; ovf_clr = 1'b0;
        repeat (3) tick();
        chk_all_zero("reset");
        reset_n = 1'b1;
        repeat (4) tick();

        // basic action scan, ir=1
        uir_scan(2'b01);
        action_ready = 1'b1;
        sr = 38'h20_0000_00AB;
        vs_udr = 1'b1;
        tick(); tick();
        chk("lat_edge2_valid", 64'(action_valid), 64'd0);
        tick();
        chk("lat_edge3_valid", 64'(action_valid), 64'd1);
        chk("lat_edge3_cnt",   64'(fifo_count), 64'd1);
        chk("lat_edge3_ir",    64'(action_ir), 64'd1);
        chk("lat_edge3_ta",    64'(take_action), 64'd0);
        tick();
        chk("pop1_ta",   64'(take_action), 64'b0010);
        chk("pop1_tna",  64'(take_no_action), 64'd0);
        chk("pop1_jdo",  64'(jdo), 64'h20_0000_00AB);
        chk("pop1_cnt",  64'(fifo_count), 64'd0);
        tick();
        chk("pop1_ta_end", 64'(take_action), 64'd0);
        chk("pop1_jdo_hold", 64'(jdo), 64'h20_0000_00AB);
        vs_udr = 1'b0;
        action_ready = 1'b0;
        repeat (4) tick();

        // no-action scan, ir=3
        uir_scan(2'b11);
        udr_scan(38'h00_1234_5678);
        chk("na_cnt", 64'(fifo_count), 64'd1);
        chk("na_ir",  64'(action_ir), 64'd3);
        chk("na_ta_idle", 64'(take_no_action), 64'd0);
        action_ready = 1'b1;
        tick();
        action_ready = 1'b0;
        chk("na_tna", 64'(take_no_action), 64'b1000);
        chk("na_ta",  64'(take_action), 64'd0);
        chk("na_jdo", 64'(jdo), 64'h00_1234_5678);
        tick();
        chk("na_tna_end", 64'(take_no_action), 64'd0);
        chk("empty_ready_ignored", 64'(take_action | take_no_action), 64'd0);

        // overflow: five scans into a depth-4 queue
        uir_scan(2'b10);
        dq[0] = 38'h20_0000_0001;
        dq[1] = 38'h00_0000_0002;
        dq[2] = 38'h3F_FFFF_FFFF;
        dq[3] = 38'h00_0000_0004;
        dq[4] = 38'h20_0000_0005;
        for (int k = 0; k < 5; k++) udr_scan(dq[k]);
        chk("ovf_cnt",   64'(fifo_count), 64'd4);
        chk("ovf_flag",  64'(overflow), 64'd1);
        chk("ovf_valid", 64'(action_valid), 64'd1);
        action_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            exp_ta  = dq[k][37] ? 4'b0100 : 4'b0000;
            exp_tna = dq[k][37] ? 4'b0000 : 4'b0100;
            chk($sformatf("ovf_pop%0d_jdo", k), 64'(jdo), 64'(dq[k]));
            chk($sformatf("ovf_pop%0d_ta", k),  64'(take_action), 64'(exp_ta));
            chk($sformatf("ovf_pop%0d_tna", k), 64'(take_no_action), 64'(exp_tna));
        end
        chk("ovf_drained", 64'(fifo_count), 64'd0);
        tick();
        chk("ovf_no_fifth_jdo", 64'(jdo), 64'(dq[3]));
        chk("ovf_no_fifth_strobe", 64'(take_action | take_no_action), 64'd0);
        chk("ovf_sticky", 64'(overflow), 64'd1);
        action_ready = 1'b0;
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_clr", 64'(overflow), 64'd0);

        // coincident uir and udr events: push uses the old ir_reg
        uir_scan(2'b00);
        ir_in = 2'b11; sr = 38'h20_0000_0077;
        vs_uir = 1'b1; vs_udr = 1'b1;
        repeat (3) tick();
        chk("simul_cnt", 64'(fifo_count), 64'd1);
        chk("simul_ir",  64'(action_ir), 64'd0);
        vs_uir = 1'b0; vs_udr = 1'b0;
        repeat (3) tick();
        action_ready = 1'b1;
        tick();
        action_ready = 1'b0;
        chk("simul_ta", 64'(take_action), 64'b0001);
        udr_scan(38'h00_0000_0099);
        chk("simul_next_ir", 64'(action_ir), 64'd3);
        action_ready = 1'b1;
        tick();
        action_ready = 1'b0;
        chk("simul_next_tna", 64'(take_no_action), 64'b1000);
        tick();

        // vs_udr held high through reset release
        reset_n = 1'b0;
        vs_udr = 1'b1; sr = 38'h20_0000_00CC;
        repeat (3) tick();
        chk("held_rst_jdo", 64'(jdo), 64'd0);
        reset_n = 1'b1;
        repeat (6) tick();
        chk("held_no_push_cnt",   64'(fifo_count), 64'd0);
        chk("held_no_push_valid", 64'(action_valid), 64'd0);
        vs_udr = 1'b0;
        repeat (4) tick();
        chk("held_low_cnt", 64'(fifo_count), 64'd0);
        vs_udr = 1'b1;
        repeat (3) tick();
        chk("held_rearm_cnt", 64'(fifo_count), 64'd1);
        vs_udr = 1'b0;
        action_ready = 1'b1;
        tick();
        action_ready = 1'b0;
        chk("held_rearm_jdo", 64'(jdo), 64'h20_0000_00CC);
        chk("held_rearm_ta",  64'(take_action), 64'b0001);
        repeat (4) tick();

        // async reset with two entries queued and a pop strobe in flight
        udr_scan(38'h20_0000_0011);
        udr_scan(38'h20_0000_0022);
        chk("mid_cnt", 64'(fifo_count), 64'd2);
        action_ready = 1'b1;
        tick();
        chk("mid_strobe", 64'(take_action), 64'b0001);
        #2;
        reset_n = 1'b0;
        #1;
        chk_all_zero("mid_rst");
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (3) tick();
        chk("post_rst_cnt", 64'(fifo_count), 64'd0);
        chk("post_rst_strobe", 64'(take_action | take_no_action), 64'd0);
        action_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/debug_cmd_sync.md
Name: debug_cmd_sync

Overview:
- Parametrised system-clock receiver for the CPU debug slave.
- Takes the asynchronous JTAG-side update strobes (vs_uir, vs_udr), the instruction code (ir_in) and the shift register (sr), and re-times them into clk with multi-stage synchronisers.
- Queues completed scans in a small command FIFO and issues per-instruction take_action / take_no_action strobes plus a held jdo word under a valid/ready handshake.
- Successor to the fixed 38-bit/2-bit-IR sysclk stage: widths, synchroniser depth and queue depth are parametrised; back-pressure and overflow reporting are new.

Parameters:
- SR_W, 38: shift register / jdo width; bit SR_W-1 is the action bit.
- IR_W, 2: instruction width; gives NCH = 2**IR_W action channels.
- SYNC_STAGES, 2: synchroniser flops per async input (legal values 2..4).
- FIFO_DEPTH, 4: number of queued scans (>=2, any integer).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- vs_uir  in  1  async level, high after instruction-register update (TCK domain).
- vs_udr  in  1  async level, high after data-register update (TCK domain).
- ir_in  in  IR_W  instruction code; stable while vs_uir is high.
- sr  in  SR_W  shifted data; stable from vs_udr rise until the next scan.
- action_ready  in  1  consumer accepts the head entry.
- ovf_clr  in  1  clears the sticky overflow flag.
- action_valid  out  1  FIFO non-empty.
- action_ir  out  IR_W  IR code of the head entry.
- jdo  out  SR_W  data of the last popped entry; held between pops.
- take_action  out  NCH  one-hot, 1-cycle strobe on pop when the action bit = 1.
- take_no_action  out  NCH  one-hot, 1-cycle strobe on pop when the action bit = 0.
- fifo_count  out  $clog2(FIFO_DEPTH+1)  current occupancy.
- overflow  out  1  sticky; a scan was dropped.

Behaviour:
- Reset (async assert, sync deassert):
  - All outputs are 0, including jdo, counts and strobes.
  - Synchroniser, edge registers, ir_reg and FIFO pointers are cleared.
  - arm_uir and arm_udr are cleared.
- Synchronisation: each of vs_uir and vs_udr passes through SYNC_STAGES flops.
- Edge detection: an event is a rising edge of the last stage, i.e. last stage = 1 and its delayed copy = 0.
- Arming after reset: an event for an input is suppressed until that input's synchronised level has been seen at 0 once (arm flag). A level held high through reset therefore never yields a spurious event.
- uir event: ir_reg <= ir_in on that edge.
- udr event: {ir_reg, sr} is pushed into the FIFO on that edge.
- Simultaneous uir and udr events in the same cycle: the push uses the OLD ir_reg, and ir_reg updates on the same edge.
- Latency:
  - Count the first clk edge that samples vs_udr high as edge 1.
  - The push happens at edge SYNC_STAGES+1.
  - action_valid goes high after that edge: edge 3 for the default.
- FIFO:
  - Circular buffer; read and write pointers wrap from FIFO_DEPTH-1 to 0.
  - fifo_count = writes - reads.
  - action_valid = (fifo_count != 0).
  - action_ir is driven combinationally from the head entry.
- Pop: occurs on an edge where action_valid & action_ready. On the following cycle:
  - jdo = popped data.
  - take_action[ir] = 1 if data[SR_W-1] = 1, otherwise take_no_action[ir] = 1.
  - All other strobe bits are 0.
  - Strobes last exactly one cycle; jdo holds until the next pop.
- Full: a push while fifo_count == FIFO_DEPTH and no pop on that edge:
  - The entry is dropped and overflow is set.
  - FIFO contents and count are unchanged.
- Push and pop on the same edge: both occur, including when full (no drop) and when count = 1. Count is unchanged.
- Empty: action_ready is ignored; no strobes are issued.
- Overflow flag:
  - ovf_clr clears it on the next edge.
  - A new overflow on the same edge as ovf_clr wins, so overflow stays 1.
- Reset mid-operation: the queue is flushed and strobes are cancelled immediately, because reset is asynchronous.

Test Plan:
- Default parameters; vs_uir pulse with ir_in=2'b01, then vs_udr with sr=38'h20_0000_00AB, action_ready=1 -> action_valid rises 3 edges after sampling; on the following cycle take_action=4'b0010 for 1 cycle; jdo=38'h20_0000_00AB held afterwards.
- sr with bit 37=0 and ir=2'b11 -> take_no_action=4'b1000 and take_action=0.
- action_ready=0, 5 udr scans with FIFO_DEPTH=4 -> fifo_count=4 and overflow=1; then ready=1 pops exactly the first 4 scans in order. ovf_clr pulse -> overflow=0.
- uir and udr events synchronised in the same cycle (ir_reg=0, new ir_in=3) -> queued entry has action_ir=0; the next scan uses ir=3.
- vs_udr held high across reset release -> no push until vs_udr goes low then high again.
- Reset asserted with 2 entries queued and a pop in flight -> all outputs 0 asynchronously, fifo_count=0, no strobe after release.
